// File: rtl/mips_multicycle_control.sv
// -----------------------------------------------------------------------------
// mips_multicycle_control
//
// Moore control FSM for a multi-cycle MIPS datapath. Walks each instruction
// through fetch, decode, execute, memory and writeback. It drives every datapath
// mux select and write enable, waits on the unified memory's ready strobe, and
// counts retired instructions.
//
// Ports
//   clock        in   rising-edge system clock
//   reset        in   asynchronous active-high reset
//   opcode       in   IR[31:26]
//   funct        in   IR[5:0]
//   zero         in   ALU zero flag (the datapath gates pcWriteCond with it)
//   memReady     in   memory completes the current access this cycle
//   pcWrite      out  unconditional PC load
//   pcWriteCond  out  PC load when zero=1
//   iorD         out  memory address select: 0=PC, 1=ALUOut
//   memRead      out  memory read request
//   memWrite     out  memory write request
//   irWrite      out  IR load
//   regDst       out  write register: 00=rt, 01=rd, 10=$ra
//   memToReg     out  write data: 00=ALUOut, 01=MDR, 10=PC
//   regWrite     out  register file write enable
//   aluSrcA      out  0=PC, 1=A
//   aluSrcB      out  00=B, 01=4, 10=signext imm, 11=signext imm<<2
//   aluOp        out  00=add, 01=sub, 10=use funct
//   pcSource     out  00=ALU, 01=ALUOut, 10=jump target, 11=A
//   illegal      out  unsupported opcode trapped
//   state        out  current state code
//   instrCount   out  retired-instruction counter
// -----------------------------------------------------------------------------
module mips_multicycle_control #(
   parameter int COUNT_W = 32,
   parameter int STATE_W = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               memReady,
   output logic               pcWrite,
   output logic               pcWriteCond,
   output logic               iorD,
   output logic               memRead,
   output logic               memWrite,
   output logic               irWrite,
   output logic [1:0]         regDst,
   output logic [1:0]         memToReg,
   output logic               regWrite,
   output logic               aluSrcA,
   output logic [1:0]         aluSrcB,
   output logic [1:0]         aluOp,
   output logic [1:0]         pcSource,
   output logic               illegal,
   output logic [STATE_W-1:0] state,
   output logic [COUNT_W-1:0] instrCount
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_JAL       = 4'd10,
      S_I_EXEC    = 4'd11,
      S_I_WB      = 4'd12,
      S_JR        = 4'd13,
      S_ILLEGAL   = 4'd14,
      S_UNUSED    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] FN_JR    = 6'b001000;

   state_t             r_state;
   state_t             w_next_state;
   logic [COUNT_W-1:0] r_instr_count;
   logic               w_retire;

   // The branch decision itself is made in the datapath (pcWriteCond & zero),
   // so the flag is not needed here.
   logic w_unused_zero;
   assign w_unused_zero = zero;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others; blocking here would create order races.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // An instruction retires whenever the FSM returns to FETCH from elsewhere.
   // ILLEGAL never returns to FETCH, so trapped opcodes are not counted.
   assign w_retire = (r_state != S_FETCH) && (w_next_state == S_FETCH);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_instr_count <= '0;
      end else if (w_retire) begin
         r_instr_count <= r_instr_count + COUNT_W'(1);
      end
   end

   always_comb begin
      // NOTE: every output gets a default first, so states that leave a signal
      // unmentioned drive 0 and no latch is inferred.
      w_next_state = S_FETCH;
      pcWrite      = 1'b0;
      pcWriteCond  = 1'b0;
      iorD         = 1'b0;
      memRead      = 1'b0;
      memWrite     = 1'b0;
      irWrite      = 1'b0;
      regDst       = 2'b00;
      memToReg     = 2'b00;
      regWrite     = 1'b0;
      aluSrcA      = 1'b0;
      aluSrcB      = 2'b00;
      aluOp        = 2'b00;
      pcSource     = 2'b00;
      illegal      = 1'b0;

      // Reset silences the outputs combinationally. Otherwise FETCH's memRead
      // would show while reset is held, and an in-flight memWrite would
      // survive until the clock edge.
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               memRead  = 1'b1;
               aluSrcB  = 2'b01;
               irWrite  = memReady;
               pcWrite  = memReady;
               w_next_state = memReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
               aluSrcB = 2'b11;
               case (opcode)
                  OP_RTYPE:     w_next_state = (funct == FN_JR) ? S_JR : S_EXECUTE;
                  OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
                  OP_BEQ:       w_next_state = S_BRANCH;
                  OP_J:         w_next_state = S_JUMP;
                  OP_JAL:       w_next_state = S_JAL;
                  OP_ADDI:      w_next_state = S_I_EXEC;
                  default:      w_next_state = S_ILLEGAL;
               endcase
            end
            S_MEM_ADDR: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
               w_next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
               memRead = 1'b1;
               iorD    = 1'b1;
               w_next_state = memReady ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
               memToReg = 2'b01;
               regWrite = 1'b1;
            end
            S_MEM_WRITE: begin
               memWrite = 1'b1;
               iorD     = 1'b1;
               w_next_state = memReady ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
               aluSrcA = 1'b1;
               aluOp   = 2'b10;
               w_next_state = S_R_WB;
            end
            S_R_WB: begin
               regDst   = 2'b01;
               regWrite = 1'b1;
            end
            S_BRANCH: begin
               aluSrcA     = 1'b1;
               aluOp       = 2'b01;
               pcWriteCond = 1'b1;
               pcSource    = 2'b01;
            end
            S_JUMP: begin
               pcWrite  = 1'b1;
               pcSource = 2'b10;
            end
            S_JAL: begin
               // PC already holds PC+4 from FETCH, so $ra captures the return
               // address on the same edge that PC takes the jump target.
               regDst   = 2'b10;
               memToReg = 2'b10;
               regWrite = 1'b1;
               pcWrite  = 1'b1;
               pcSource = 2'b10;
            end
            S_I_EXEC: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
               w_next_state = S_I_WB;
            end
            S_I_WB: begin
               regWrite = 1'b1;
            end
            S_JR: begin
               pcWrite  = 1'b1;
               pcSource = 2'b11;
            end
            S_ILLEGAL: begin
               illegal      = 1'b1;
               w_next_state = S_ILLEGAL;
            end
            default: begin
               // Code 15 is unreachable; recover to FETCH with all outputs idle.
               w_next_state = S_FETCH;
            end
         endcase
      end
   end

   assign state      = STATE_W'(r_state);
   assign instrCount = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_control
//
// Self-checking bench for mips_multicycle_control. Expected behaviour comes
// from two sources. The first is a per-state table of control words. The second
// is an instruction-level model that expands each opcode into its list of
// states, stretches the memory steps while memReady is low, and counts
// completed instructions.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_control;

   logic        clock;
   logic        reset;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        memReady;
   logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
   logic [1:0]  regDst, memToReg;
   logic        regWrite, aluSrcA;
   logic [1:0]  aluSrcB, aluOp, pcSource;
   logic        illegal;
   logic [3:0]  state;
   logic [31:0] instrCount;

   mips_multicycle_control #(
      .COUNT_W (32),
      .STATE_W (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .memReady    (memReady),
      .pcWrite     (pcWrite),
      .pcWriteCond (pcWriteCond),
      .iorD        (iorD),
      .memRead     (memRead),
      .memWrite    (memWrite),
      .irWrite     (irWrite),
      .regDst      (regDst),
      .memToReg    (memToReg),
      .regWrite    (regWrite),
      .aluSrcA     (aluSrcA),
      .aluSrcB     (aluSrcB),
      .aluOp       (aluOp),
      .pcSource    (pcSource),
      .illegal     (illegal),
      .state       (state),
      .instrCount  (instrCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic [1:0] regDst;
      logic [1:0] memToReg;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] pcSource;
      logic       illegal;
   } ctl_t;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         n;
      int         seq[5];
   } vec_t;

   ctl_t        act;
   ctl_t        ctl_tab[16];
   vec_t        vecs[$];
   int          n_pass;
   int          n_total;
   logic [31:0] m_count;

   assign act = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                 regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp,
                 pcSource, illegal};

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
   endtask

   // Control word for each state code, written straight from the state list.
   task automatic init_tab();
      ctl_t c;
      for (int i = 0; i < 16; i++) ctl_tab[i] = '0;
      c = '0; c.memRead = 1; c.aluSrcB = 2'b01;                          ctl_tab[0]  = c;
      c = '0; c.aluSrcB = 2'b11;                                         ctl_tab[1]  = c;
      c = '0; c.aluSrcA = 1; c.aluSrcB = 2'b10;                          ctl_tab[2]  = c;
      c = '0; c.memRead = 1; c.iorD = 1;                                 ctl_tab[3]  = c;
      c = '0; c.memToReg = 2'b01; c.regWrite = 1;                        ctl_tab[4]  = c;
      c = '0; c.memWrite = 1; c.iorD = 1;                                ctl_tab[5]  = c;
      c = '0; c.aluSrcA = 1; c.aluOp = 2'b10;                            ctl_tab[6]  = c;
      c = '0; c.regDst = 2'b01; c.regWrite = 1;                          ctl_tab[7]  = c;
      c = '0; c.aluSrcA = 1; c.aluOp = 2'b01; c.pcWriteCond = 1; c.pcSource = 2'b01;
      ctl_tab[8] = c;
      c = '0; c.pcWrite = 1; c.pcSource = 2'b10;                         ctl_tab[9]  = c;
      c = '0; c.regDst = 2'b10; c.memToReg = 2'b10; c.regWrite = 1; c.pcWrite = 1;
      c.pcSource = 2'b10;                                                ctl_tab[10] = c;
      c = '0; c.aluSrcA = 1; c.aluSrcB = 2'b10;                          ctl_tab[11] = c;
      c = '0; c.regWrite = 1;                                            ctl_tab[12] = c;
      c = '0; c.pcWrite = 1; c.pcSource = 2'b11;                         ctl_tab[13] = c;
      c = '0; c.illegal = 1;                                             ctl_tab[14] = c;
   endtask

   function automatic ctl_t exp_ctl(input int st, input logic rdy);
      ctl_t c;
      c = ctl_tab[st];
      if (st == 0) begin
         c.irWrite = rdy;
         c.pcWrite = rdy;
      end
      return c;
   endfunction

   task automatic add_vec(input string nm, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int n,
                          input int s0, input int s1, input int s2, input int s3, input int s4);
      vec_t v;
      v.name = nm; v.op = op; v.fn = fn; v.z = z; v.n = n;
      v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
      vecs.push_back(v);
   endtask

   // One clock cycle: called just after a falling edge. It drives memReady,
   // checks state, control word and counter, then waits for the next falling edge.
   task automatic cycle_check(input string nm, input int st, input logic rdy);
      memReady = rdy;
      #1;
      check({nm, " state"}, 32'(state), 32'(st));
      check({nm, " ctl"}, 32'(act), 32'(exp_ctl(st, rdy)));
      check({nm, " count"}, instrCount, m_count);
      @(negedge clock);
   endtask

   // Instruction-level model: the list of states an opcode passes through.
   function automatic void instr_steps(input logic [5:0] op, input logic [5:0] fn, ref int q[$]);
      q = '{0, 1};
      case (op)
         6'b000000: if (fn == 6'b001000) q.push_back(13);
                    else begin q.push_back(6); q.push_back(7); end
         6'b100011: begin q.push_back(2); q.push_back(3); q.push_back(4); end
         6'b101011: begin q.push_back(2); q.push_back(5); end
         6'b000100: q.push_back(8);
         6'b000010: q.push_back(9);
         6'b000011: q.push_back(10);
         6'b001000: begin q.push_back(11); q.push_back(12); end
         default:   q.push_back(14);
      endcase
   endfunction

   function automatic bit is_mem_step(input int st);
      return (st == 0) || (st == 3) || (st == 5);
   endfunction

   task automatic run_random_instr();
      int          q[$];
      int          waits;
      logic        rdy;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [5:0]  ops[7];
      int          k;
      ops = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000011, 6'b001000};
      k  = $urandom_range(0, 7);
      fn = 6'($urandom);
      if (k == 7) op = 6'b000010;
      else op = ops[k];
      if (k == 0 && fn == 6'b001000) fn = 6'b100000;
      if (k == 1) fn = 6'b001000;
      opcode = op;
      funct  = fn;
      zero   = 1'($urandom);
      instr_steps(op, fn, q);
      foreach (q[i]) begin
         waits = 0;
         do begin
            rdy = ($urandom_range(0, 2) != 0);
            if (waits >= 4) rdy = 1'b1;
            if (!is_mem_step(q[i])) rdy = 1'($urandom);
            cycle_check("rand", q[i], rdy);
            waits++;
         end while (is_mem_step(q[i]) && !rdy);
      end
      m_count++;
   endtask

   initial begin
      n_pass = 0; n_total = 0; m_count = '0;
      reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; memReady = 1'b0;
      init_tab();

      // Reset state.
      #2;
      check("reset state", 32'(state), 32'd0);
      check("reset ctl", 32'(act), 32'd0);
      check("reset count", instrCount, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Table-driven single instructions with memReady tied high.
      add_vec("add",    6'b000000, 6'b100000, 1'b0, 4, 0, 1, 6, 7, 0);
      add_vec("addi",   6'b001000, 6'b000000, 1'b0, 4, 0, 1, 11, 12, 0);
      add_vec("lw",     6'b100011, 6'b000000, 1'b0, 5, 0, 1, 2, 3, 4);
      add_vec("sw",     6'b101011, 6'b000000, 1'b0, 4, 0, 1, 2, 5, 0);
      add_vec("beq z1", 6'b000100, 6'b000000, 1'b1, 3, 0, 1, 8, 0, 0);
      add_vec("beq z0", 6'b000100, 6'b000000, 1'b0, 3, 0, 1, 8, 0, 0);
      add_vec("j",      6'b000010, 6'b000000, 1'b0, 3, 0, 1, 9, 0, 0);
      add_vec("jal",    6'b000011, 6'b000000, 1'b0, 3, 0, 1, 10, 0, 0);
      add_vec("jr",     6'b000000, 6'b001000, 1'b0, 3, 0, 1, 13, 0, 0);
      foreach (vecs[v]) begin
         opcode = vecs[v].op;
         funct  = vecs[v].fn;
         zero   = vecs[v].z;
         for (int k = 0; k < vecs[v].n; k++) cycle_check(vecs[v].name, vecs[v].seq[k], 1'b1);
         m_count++;
      end

      // lw with two FETCH waits and three MEM_READ waits: 10 cycles in total.
      opcode = 6'b100011; funct = '0;
      cycle_check("lw wait", 0, 1'b0);
      cycle_check("lw wait", 0, 1'b0);
      cycle_check("lw wait", 0, 1'b1);
      cycle_check("lw wait", 1, 1'b1);
      cycle_check("lw wait", 2, 1'b1);
      cycle_check("lw wait", 3, 1'b0);
      cycle_check("lw wait", 3, 1'b0);
      cycle_check("lw wait", 3, 1'b0);
      cycle_check("lw wait", 3, 1'b1);
      cycle_check("lw wait", 4, 1'b1);
      m_count++;

      // Random instruction stream against the instruction-level model.
      for (int i = 0; i < 150; i++) run_random_instr();

      // Asynchronous reset asserted mid-cycle.
      #2 reset = 1'b1;
      #1;
      check("async rst state", 32'(state), 32'd0);
      check("async rst ctl", 32'(act), 32'd0);
      check("async rst count", instrCount, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      m_count = '0;
      opcode = 6'b000000; funct = 6'b100000;
      cycle_check("after rst", 0, 1'b1);
      cycle_check("after rst", 1, 1'b1);
      cycle_check("after rst", 6, 1'b1);
      cycle_check("after rst", 7, 1'b1);
      m_count++;

      // Illegal opcode: trapped, held for 20 cycles, counter frozen.
      opcode = 6'b111111;
      cycle_check("illegal", 0, 1'b1);
      cycle_check("illegal", 1, 1'b1);
      for (int i = 0; i < 20; i++) cycle_check("illegal hold", 14, 1'($urandom));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      m_count = '0;

      // Retire one instruction, then reset during MEM_WRITE of sw.
      opcode = 6'b001000;
      cycle_check("addi", 0, 1'b1);
      cycle_check("addi", 1, 1'b1);
      cycle_check("addi", 11, 1'b1);
      cycle_check("addi", 12, 1'b1);
      m_count++;
      opcode = 6'b101011;
      cycle_check("sw rst", 0, 1'b1);
      cycle_check("sw rst", 1, 1'b1);
      cycle_check("sw rst", 2, 1'b1);
      cycle_check("sw rst", 5, 1'b0);
      memReady = 1'b0;
      #1;
      check("sw memWrite before rst", 32'(memWrite), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("sw memWrite after rst", 32'(memWrite), 32'd0);
      check("sw rst state", 32'(state), 32'd0);
      check("sw rst count", instrCount, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      m_count = '0;
      cycle_check("post sw rst", 0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
